// File: rtl/board_move_if.sv
// Move request / result bundle between the direction decoder, the move engine
// and the board register path.
interface board_move_if #(
   parameter int TILE_W  = 4,
   parameter int SCORE_W = 20
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_dir;
   logic [16*TILE_W-1:0]  board_in;
   logic [16*TILE_W-1:0]  board_out;
   logic [SCORE_W-1:0]    score_delta;
   logic                  moved;
   logic                  won;
   logic                  done;

   modport master (
      output cmd_valid, cmd_dir, board_in,
      input  cmd_ready, board_out, score_delta, moved, won, done
   );

   modport slave (
      input  cmd_valid, cmd_dir, board_in,
      output cmd_ready, board_out, score_delta, moved, won, done
   );
endinterface

// File: rtl/board_move_engine.sv
// 2048 move engine: slides/merges one row or column per clock on a 4x4 board.
// Optional random tile spawn after a real move is enabled with BOARD_SPAWN_EN.
//
// state   | meaning
// IDLE    | waiting for a move request, cmd_ready high
// LINE    | processing line cnt_q (0..3) of the working board
// SPAWN   | (BOARD_SPAWN_EN only) drop a new tile into the result board
// DONE_ST | results valid, done high; also accepts the next request
module board_move_engine #(
   parameter int          TILE_W    = 4,
   parameter int          SCORE_W   = 20,
   parameter int          WIN_EXP   = 11,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst_n,
   board_move_if.slave   bus
);

   typedef logic [TILE_W-1:0]         tile_t;
   typedef logic [3:0][TILE_W-1:0]    line_t;
   typedef logic [15:0][TILE_W-1:0]   board_t;

   typedef struct packed {
      line_t       tiles;
      logic [31:0] score;
   } slide_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LINE    = 2'd1,
      DONE_ST = 2'd2
`ifdef BOARD_SPAWN_EN
      ,
      SPAWN   = 2'd3
`endif
   } state_t;

   localparam tile_t       TILE_MAX  = '1;
   localparam tile_t       WIN_T     = tile_t'(WIN_EXP);
   localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end

   // Board index of element e of line k; element 0 sits on the side the tiles move toward.
   function automatic logic [3:0] tile_idx(input logic [1:0] dir,
                                           input logic [1:0] k,
                                           input logic [1:0] e);
      case (dir)
         2'b00:   return {e, k};
         2'b01:   return {~e, k};
         2'b10:   return {k, e};
         default: return {k, ~e};
      endcase
   endfunction

   function automatic slide_t slide_line(input line_t line_in);
      logic [4:0][TILE_W-1:0] comp;
      line_t                  merged;
      logic [2:0]             n;
      logic [2:0]             j;
      logic                   skip;
      logic [31:0]            score;
      slide_t                 res;
      comp   = '0;
      merged = '0;
      n      = 3'd0;
      j      = 3'd0;
      skip   = 1'b0;
      score  = 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (line_in[i] != '0) begin
            comp[n] = line_in[i];
            n       = n + 3'd1;
         end
      end
      // comp[4] is always empty, so the last element never finds a partner.
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[i] != '0 && comp[i] == comp[i+1] && comp[i] != TILE_MAX) begin
            merged[j[1:0]] = comp[i] + 1'b1;
            score          = score + (32'd1 << (comp[i] + 1'b1));
            skip           = 1'b1;
            j              = j + 3'd1;
         end else begin
            merged[j[1:0]] = comp[i];
            j              = j + 3'd1;
         end
      end
      res.tiles = merged;
      res.score = score;
      return res;
   endfunction

   state_t              state_q, state_d;
   board_t              work_q;
   logic [1:0]          dir_q;
   logic [1:0]          cnt_q;
   logic [SCORE_W-1:0]  score_acc_q;
   logic                moved_acc_q;
   board_t              board_out_q;
   logic [SCORE_W-1:0]  score_delta_q;
   logic                moved_q;
   logic                won_q;

   logic                cmd_ready;
   logic                accept;
   line_t               old_line;
   line_t               new_line;
   slide_t              slide_res;
   board_t              work_next;
   logic                moved_final;
   logic                won_next;
   logic [31:0]         acc_wide;
   logic [SCORE_W-1:0]  score_sat;

   assign cmd_ready = (state_q == IDLE) || (state_q == DONE_ST);
   assign accept    = bus.cmd_valid & cmd_ready;

   always_comb begin
      old_line  = '0;
      work_next = work_q;
      for (int e = 0; e < 4; e++) begin
         old_line[e] = work_q[tile_idx(dir_q, cnt_q, 2'(e))];
      end
      slide_res = slide_line(old_line);
      new_line  = slide_res.tiles;
      for (int e = 0; e < 4; e++) begin
         work_next[tile_idx(dir_q, cnt_q, 2'(e))] = new_line[e];
      end
      moved_final = moved_acc_q | (new_line != old_line);
      won_next    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (work_next[i] >= WIN_T) won_next = 1'b1;
      end
      acc_wide  = 32'(score_acc_q) + slide_res.score;
      score_sat = (acc_wide > SCORE_MAX) ? '1 : acc_wide[SCORE_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = LINE;
         end
         DONE_ST: begin
            state_d = accept ? LINE : IDLE;
         end
         LINE: begin
            if (cnt_q == 2'd3) begin
`ifdef BOARD_SPAWN_EN
               state_d = moved_final ? SPAWN : DONE_ST;
`else
               state_d = DONE_ST;
`endif
            end
         end
`ifdef BOARD_SPAWN_EN
         SPAWN: begin
            state_d = DONE_ST;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef BOARD_SPAWN_EN
   logic [15:0] lfsr_q;
   board_t      spawn_board;
   logic        spawn_found;
   logic [3:0]  spawn_pos;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   // lfsr_q during SPAWN is the value loaded on the edge that entered SPAWN.
   always_comb begin
      spawn_board = board_out_q;
      spawn_found = 1'b0;
      spawn_pos   = 4'd0;
      for (int s = 0; s < 16; s++) begin
         spawn_pos = lfsr_q[3:0] + 4'(s);
         if (!spawn_found && board_out_q[spawn_pos] == '0) begin
            spawn_found            = 1'b1;
            spawn_board[spawn_pos] = (lfsr_q[7:4] == 4'd0) ? tile_t'(2) : tile_t'(1);
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q        <= '0;
         dir_q         <= 2'd0;
         cnt_q         <= 2'd0;
         score_acc_q   <= '0;
         moved_acc_q   <= 1'b0;
         board_out_q   <= '0;
         score_delta_q <= '0;
         moved_q       <= 1'b0;
         won_q         <= 1'b0;
      end else if (accept) begin
         work_q      <= bus.board_in;
         dir_q       <= bus.cmd_dir;
         cnt_q       <= 2'd0;
         score_acc_q <= '0;
         moved_acc_q <= 1'b0;
      end else if (state_q == LINE) begin
         work_q      <= work_next;
         cnt_q       <= cnt_q + 2'd1;
         score_acc_q <= score_sat;
         moved_acc_q <= moved_final;
         if (cnt_q == 2'd3) begin
            board_out_q   <= work_next;
            score_delta_q <= score_sat;
            moved_q       <= moved_final;
            won_q         <= won_next;
         end
`ifdef BOARD_SPAWN_EN
      end else if (state_q == SPAWN) begin
         board_out_q <= spawn_board;
`endif
      end
   end

   assign bus.cmd_ready   = cmd_ready;
   assign bus.board_out   = board_out_q;
   assign bus.score_delta = score_delta_q;
   assign bus.moved       = moved_q;
   assign bus.won         = won_q;
   assign bus.done        = (state_q == DONE_ST);

endmodule

// File: tb/tb_board_move_engine.sv
// Scoreboard bench for board_move_engine: the driver queues hand-computed
// results on accept, a negedge monitor pops and compares on every done.
module tb_board_move_engine;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   int   last_acc;
   int   move_id;
   logic prev_done;

   typedef struct {
      int          id;
      logic [63:0] board;
      logic [19:0] score;
      logic        moved;
      logic        won;
      int          acc_cyc;
   } exp_t;

   exp_t exp_q[$];

   board_move_if #(.TILE_W(4), .SCORE_W(20)) bus ();

   board_move_engine #(
      .TILE_W(4), .SCORE_W(20), .WIN_EXP(11), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int id, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s move=%0d actual=%0h required=%0h", name, id, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (prev_done) chk("done_width", -1, 64'(bus.done), 64'd0);
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("board_out", e.id, bus.board_out, e.board);
               chk("score_delta", e.id, 64'(bus.score_delta), 64'(e.score));
               chk("moved", e.id, 64'(bus.moved), 64'(e.moved));
               chk("won", e.id, 64'(bus.won), 64'(e.won));
               chk("latency", e.id, 64'(cyc - e.acc_cyc), 64'd4);
            end
         end
      end
      prev_done = bus.done;
   end

   task automatic move(input logic [63:0] b, input logic [1:0] d, input logic [63:0] eb,
                       input logic [19:0] es, input logic em, input logic ew);
      exp_t e;
      int   waited;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = d;
      bus.board_in  = b;
      waited        = 0;
      while (!bus.cmd_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout move=%0d actual=busy required=ready", move_id);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      last_acc      = cyc;
      e.id          = move_id;
      e.board       = eb;
      e.score       = es;
      e.moved       = em;
      e.won         = ew;
      e.acc_cyc     = cyc;
      exp_q.push_back(e);
      move_id++;
      bus.cmd_valid = 1'b0;
      bus.board_in  = ~b;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_board_out"}, -1, bus.board_out, 64'd0);
      chk({tag, "_score_delta"}, -1, 64'(bus.score_delta), 64'd0);
      chk({tag, "_moved"}, -1, 64'(bus.moved), 64'd0);
      chk({tag, "_won"}, -1, 64'(bus.won), 64'd0);
      chk({tag, "_done"}, -1, 64'(bus.done), 64'd0);
      chk({tag, "_cmd_ready"}, -1, 64'(bus.cmd_ready), 64'd1);
   endtask

   initial begin
      int a1;
      cyc           = 0;
      checks        = 0;
      failures      = 0;
      move_id       = 0;
      prev_done     = 1'b0;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_dir   = 2'b00;
      bus.board_in  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_values("reset");

      move(64'h0000_0000_0000_2211, 2'b10, 64'h0000_0000_0000_0032, 20'd12, 1'b1, 1'b0);
      drain();

      // Second request is raised while the first is in flight and must land 5 cycles later.
      move(64'h0000_0000_0000_1111, 2'b11, 64'h0000_0000_0000_2200, 20'd8, 1'b1, 1'b0);
      a1 = last_acc;
      move(64'h0001_0000_0001_0000, 2'b00, 64'h0000_0000_0000_0002, 20'd4, 1'b1, 1'b0);
      chk("b2b_spacing", -1, 64'(last_acc - a1), 64'd5);

      move(64'h0000_0000_0000_0123, 2'b10, 64'h0000_0000_0000_0123, 20'd0, 1'b0, 1'b0);
      move(64'h0000_0000_0000_00AA, 2'b10, 64'h0000_0000_0000_000B, 20'd2048, 1'b1, 1'b1);
      move(64'h0000_0000_0000_2002, 2'b10, 64'h0000_0000_0000_0003, 20'd8, 1'b1, 1'b0);
      move(64'h0000_0000_0000_0211, 2'b10, 64'h0000_0000_0000_0022, 20'd4, 1'b1, 1'b0);
      move(64'h0000_1000_1000_1000, 2'b01, 64'h2000_1000_0000_0000, 20'd4, 1'b1, 1'b0);
      move(64'h4404_1000_3322_1111, 2'b10, 64'h0045_0001_0043_0022, 20'd64, 1'b1, 1'b0);
      move(64'h0000_0000_00FF_0000, 2'b10, 64'h0000_0000_00FF_0000, 20'd0, 1'b0, 1'b1);
      drain();
      chk("hold_board_out", -1, bus.board_out, 64'h0000_0000_00FF_0000);

      // Leave a nonzero result on the outputs, then abort a move mid-flight.
      move(64'h0000_0000_0000_00AA, 2'b10, 64'h0000_0000_0000_000B, 20'd2048, 1'b1, 1'b1);
      drain();
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_dir   = 2'b10;
      bus.board_in  = 64'h0000_0000_0000_2211;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_values("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done_board", -1, bus.board_out, 64'd0);

      move(64'h0000_0000_0000_2211, 2'b10, 64'h0000_0000_0000_0032, 20'd12, 1'b1, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
